// File: rtl/sam_delay_search_ctrl_pkg.sv
// Shared definitions for the sample-delay search controller: FSM encoding and
// the default error width.
package sam_delay_search_ctrl_pkg;

    localparam int ERR_W_DEFAULT = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_MEASURE,
        ST_COMPARE,
        ST_LOCKED
    } state_t;

endpackage

// File: rtl/sam_delay_search_ctrl_err_min_track.sv
// Running-minimum tracker: keeps the smallest value seen since the last clear
// and the index it arrived with. Strict compare, so ties keep the earlier index.
module err_min_track #(
    parameter int VAL_W = 18,
    parameter int IDX_W = 2
) (
    input  logic             sys_clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [VAL_W-1:0] value,
    input  logic [IDX_W-1:0] index,
    output logic             better,
    output logic [VAL_W-1:0] best_val,
    output logic [IDX_W-1:0] best_idx
);

    assign better = (value < best_val);

    // NOTE: every register here is reset asynchronously; there is no memory array, so nothing is left uninitialised.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            best_val <= '1;
            best_idx <= '0;
        end else if (clear) begin
            best_val <= '1;
            best_idx <= '0;
        end else if (load && better) begin
            best_val <= value;
            best_idx <= index;
        end
    end

endmodule

// File: rtl/sam_delay_search_ctrl.sv
// Sweeps every candidate sample delay, measures the accumulated squared error
// for each after a settling interval, and locks onto the lowest-error delay.
module sam_delay_search_ctrl
    import sam_delay_search_ctrl_pkg::*;
#(
    parameter int DELAY_STEPS    = 4,
    parameter int SETTLE_PERIODS = 2,
    parameter int ERR_W          = ERR_W_DEFAULT
) (
    input  logic                           sys_clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           cycle_periodic,
    input  logic [ERR_W-1:0]               acc_sq_err,
    output logic [$clog2(DELAY_STEPS)-1:0] sam_delay,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(DELAY_STEPS)-1:0] best_delay,
    output logic [ERR_W-1:0]               best_err
);

    localparam int DW = $clog2(DELAY_STEPS);
    localparam int SW = (SETTLE_PERIODS > 0) ? $clog2(SETTLE_PERIODS + 1) : 1;
    localparam logic [DW-1:0] LAST_CAND   = DW'(DELAY_STEPS - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_PERIODS);

    state_t            state, state_next;
    logic [DW-1:0]     candidate;
    logic [SW-1:0]     settle_cnt;
    logic [ERR_W-1:0]  meas_err;
    logic              clear_best, load_best, better;

    err_min_track #(
        .VAL_W (ERR_W),
        .IDX_W (DW)
    ) u_min (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .clear    (clear_best),
        .load     (load_best),
        .value    (meas_err),
        .index    (candidate),
        .better   (better),
        .best_val (best_err),
        .best_idx (best_delay)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
    always_comb begin
        state_next = state;
        clear_best = 1'b0;
        load_best  = 1'b0;
        unique case (state)
            ST_IDLE, ST_LOCKED: begin
                if (start) begin
                    state_next = ST_APPLY;
                    clear_best = 1'b1;
                end
            end
            ST_APPLY: state_next = ST_SETTLE;
            ST_SETTLE: begin
                // A zero count on entry means no settling pulses are discarded.
                if (settle_cnt == '0)
                    state_next = ST_MEASURE;
                else if (cycle_periodic && settle_cnt == SW'(1))
                    state_next = ST_MEASURE;
            end
            ST_MEASURE: if (cycle_periodic) state_next = ST_COMPARE;
            ST_COMPARE: begin
                load_best  = 1'b1;
                state_next = (candidate == LAST_CAND) ? ST_LOCKED : ST_APPLY;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            candidate  <= '0;
            settle_cnt <= '0;
            meas_err   <= '0;
            sam_delay  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_LOCKED: begin
                    if (start) begin
                        candidate <= '0;
                        sam_delay <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                ST_APPLY: settle_cnt <= SETTLE_LOAD;
                ST_SETTLE: begin
                    if (cycle_periodic && settle_cnt != '0)
                        settle_cnt <= settle_cnt - SW'(1);
                end
                ST_MEASURE: if (cycle_periodic) meas_err <= acc_sq_err;
                ST_COMPARE: begin
                    if (candidate == LAST_CAND) begin
                        // The tracker updates on this same edge, so pick the winner here.
                        sam_delay <= better ? candidate : best_delay;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        candidate <= candidate + DW'(1);
                        sam_delay <= candidate + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sam_delay_search_ctrl.sv
// Bench for sam_delay_search_ctrl: a plant returns an error per applied delay,
// searches are compared against an argmin reference model and fixed vectors.
module tb_sam_delay_search_ctrl;

    localparam int EW = 18;
    localparam logic [EW-1:0] ALL_ONES = '1;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_req = 1'b0;
    logic          sel = 1'b0;
    logic          cycle_periodic = 1'b0;
    logic          start0, start2;
    logic [EW-1:0] acc0, acc2;
    logic [1:0]    sd0, sd2, bd0, bd2;
    logic          busy0, busy2, done0, done2;
    logic [EW-1:0] be0, be2;
    logic [EW-1:0] plant [4];

    logic [1:0]    m_sd, m_bd;
    logic          m_busy, m_done;
    logic [EW-1:0] m_be;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [EW-1:0] e [4];
        bit            s0;
        int            exp_d;
        logic [EW-1:0] exp_e;
    } vec_t;

    vec_t vt [4];

    // The plant: error seen depends on the delay each DUT currently applies.
    assign acc0   = plant[sd0];
    assign acc2   = plant[sd2];
    assign start0 = start_req & sel;
    assign start2 = start_req & ~sel;
    assign m_sd   = sel ? sd0 : sd2;
    assign m_bd   = sel ? bd0 : bd2;
    assign m_be   = sel ? be0 : be2;
    assign m_busy = sel ? busy0 : busy2;
    assign m_done = sel ? done0 : done2;

    always #5 sys_clk = ~sys_clk;

    sam_delay_search_ctrl #(.DELAY_STEPS(4), .SETTLE_PERIODS(0), .ERR_W(EW)) dut0 (
        .sys_clk(sys_clk), .reset(reset), .start(start0), .cycle_periodic(cycle_periodic),
        .acc_sq_err(acc0), .sam_delay(sd0), .busy(busy0), .done(done0),
        .best_delay(bd0), .best_err(be0)
    );

    sam_delay_search_ctrl #(.DELAY_STEPS(4), .SETTLE_PERIODS(2), .ERR_W(EW)) dut2 (
        .sys_clk(sys_clk), .reset(reset), .start(start2), .cycle_periodic(cycle_periodic),
        .acc_sq_err(acc2), .sam_delay(sd2), .busy(busy2), .done(done2),
        .best_delay(bd2), .best_err(be2)
    );

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: smallest error wins, first occurrence on ties.
    task automatic ref_best(output int idx, output logic [EW-1:0] val);
        idx = 0;
        val = ALL_ONES;
        for (int i = 0; i < 4; i++)
            if (plant[i] < val) begin
                val = plant[i];
                idx = i;
            end
    endtask

    function automatic vec_t mk(input int e0, e1, e2, e3, input bit s0, input int d, input int err);
        vec_t v;
        v.e[0] = EW'(e0); v.e[1] = EW'(e1); v.e[2] = EW'(e2); v.e[3] = EW'(e3);
        v.s0 = s0; v.exp_d = d; v.exp_e = EW'(err);
        return v;
    endfunction

    // One pulse every 6 cycles keeps pulses away from APPLY/COMPARE cycles.
    task automatic run_search(input bit s0, input int restart_at, input int abort_at,
                              output int pulses, output bit aborted);
        int phase;
        sel = s0;
        pulses = 0;
        aborted = 1'b0;
        @(negedge sys_clk) start_req = 1'b1;
        @(negedge sys_clk) start_req = 1'b0;
        check("busy_after_start", m_busy, 1);
        check("done_after_start", m_done, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (m_done) break;
            phase = cyc % 6;
            if (abort_at > 0 && pulses == abort_at && phase == 1) begin
                aborted = 1'b1;
                break;
            end
            cycle_periodic = (phase == 0);
            if (phase == 0) pulses++;
            start_req = (restart_at > 0 && pulses == restart_at && phase == 1);
            @(negedge sys_clk);
        end
        cycle_periodic = 1'b0;
        start_req = 1'b0;
        if (!aborted) check("search_finished", m_done, 1);
    endtask

    task automatic verify(input string tag, input int exp_d, input logic [EW-1:0] exp_e,
                          input int pulses, input int exp_pulses);
        check({tag, "_done"}, m_done, 1);
        check({tag, "_busy"}, m_busy, 0);
        check({tag, "_best_delay"}, m_bd, exp_d);
        check({tag, "_best_err"}, m_be, exp_e);
        check({tag, "_sam_delay"}, m_sd, exp_d);
        check({tag, "_pulses"}, pulses, exp_pulses);
    endtask

    initial begin
        int pulses, ref_d;
        bit aborted;
        logic [EW-1:0] ref_e;

        vt[0] = mk(900, 120, 450, 300, 1'b0, 1, 120);
        vt[1] = mk(50, 50, 80, 90, 1'b0, 0, 50);
        vt[2] = mk(7, 3, 9, 8, 1'b1, 1, 3);
        vt[3] = mk(1, 1, 1, 0, 1'b1, 3, 0);

        repeat (3) @(negedge sys_clk);
        check("rst_busy", busy2, 0);
        check("rst_done", done2, 0);
        check("rst_sam_delay", sd2, 0);
        check("rst_best_delay", bd2, 0);
        check("rst_best_err", be2, ALL_ONES);
        reset = 1'b1;
        @(negedge sys_clk);

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) plant[i] = vt[v].e[i];
            run_search(vt[v].s0, 0, 0, pulses, aborted);
            verify($sformatf("vec%0d", v), vt[v].exp_d, vt[v].exp_e, pulses, vt[v].s0 ? 4 : 12);
        end

        // Start re-pulsed while delay 2 is settling must not restart the sweep.
        plant[0] = 18'd900; plant[1] = 18'd120; plant[2] = 18'd450; plant[3] = 18'd300;
        run_search(1'b0, 7, 0, pulses, aborted);
        verify("restart_ignored", 1, 18'd120, pulses, 12);

        // Reset while measuring delay 2 abandons everything.
        run_search(1'b0, 0, 8, pulses, aborted);
        check("abort_reached", aborted, 1);
        reset = 1'b0;
        @(negedge sys_clk);
        check("abort_busy", busy2, 0);
        check("abort_done", done2, 0);
        check("abort_sam_delay", sd2, 0);
        check("abort_best_delay", bd2, 0);
        check("abort_best_err", be2, ALL_ONES);
        reset = 1'b1;
        @(negedge sys_clk);
        plant[0] = 18'd10; plant[1] = 18'd20; plant[2] = 18'd30; plant[3] = 18'd5;
        run_search(1'b0, 0, 0, pulses, aborted);
        verify("after_abort", 3, 18'd5, pulses, 12);

        for (int r = 0; r < 10; r++) begin
            bit s0;
            s0 = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++)
                plant[i] = (r % 2 == 0) ? EW'($urandom_range(0, 3)) : EW'($urandom);
            ref_best(ref_d, ref_e);
            run_search(s0, 0, 0, pulses, aborted);
            verify($sformatf("rand%0d", r), ref_d, ref_e, pulses, s0 ? 4 : 12);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
